// File: rtl/multicycle_control.sv
// multicycle_control -- control FSM for a multicycle datapath.
//
// Sequences fetch (IF), decode (DEC), execute (EX_R / EX_I / ADDR / BR),
// data access (MEM) and write-back (WB_ALU / WB_MEM). Any unknown opcode,
// or a memory request left unacknowledged for TIMEOUT cycles, parks the
// FSM in FAULT until reset.
//
// Ports
//   Clk            rising-edge clock
//   Reset          asynchronous reset, active low
//   Instr[31:0]    instruction register contents, opcode = Instr[31:26]
//   Zero           ALU zero flag (used in BR)
//   Mem_Ack        one-cycle memory completion strobe
//   PC_sel         0 = PC+4, 1 = branch target
//   PC_LdEn        PC load enable
//   IR_LdEn        instruction register load enable
//   RF_WrEn        register file write enable
//   RF_WrData_sel  0 = ALU result, 1 = memory data
//   ALU_Bin_sel    0 = register B, 1 = immediate
//   ALU_func       ALU operation code
//   MEM_WrEn       data memory write enable
//   Mem_Req        memory request (fetch or data)
//   Retired[31:0]  retired-instruction count (only with CTRL_RETIRED_CNT_EN)
//   Fault          sticky fault flag
//
// Optional feature macro: CTRL_RETIRED_CNT_EN adds the Retired counter.
module multicycle_control #(
  parameter int FUNC_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Instr,
  input  logic              Zero,
  input  logic              Mem_Ack,
  output logic              PC_sel,
  output logic              PC_LdEn,
  output logic              IR_LdEn,
  output logic              RF_WrEn,
  output logic              RF_WrData_sel,
  output logic              ALU_Bin_sel,
  output logic [FUNC_W-1:0] ALU_func,
  output logic              MEM_WrEn,
  output logic              Mem_Req,
`ifdef CTRL_RETIRED_CNT_EN
  output logic [31:0]       Retired,
`endif
  output logic              Fault
);

  typedef enum logic [3:0] {
    S_IF, S_DEC, S_EX_R, S_EX_I, S_ADDR, S_MEM, S_WB_ALU, S_WB_MEM, S_BR, S_FAULT
  } state_t;

  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b010000;
  localparam logic [5:0] OP_BNE  = 6'b010001;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic [5:0] opc;
  logic       take;

  assign opc = Instr[31:26];

  // Only the opcode and function field are decoded here.
  logic unused_instr;
  assign unused_instr = ^Instr[25:FUNC_W];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Counts request cycles of the current access; cleared whenever IF or MEM
  // is entered so each access gets a fresh TIMEOUT budget.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      wait_cnt <= '0;
    else if (state_d != state_q && (state_d == S_IF || state_d == S_MEM))
      wait_cnt <= '0;
    else if (Mem_Req)
      wait_cnt <= wait_cnt + 8'd1;
  end

  always_comb begin
    state_d       = state_q;
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    IR_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = '0;
    MEM_WrEn      = 1'b0;
    Mem_Req       = 1'b0;
    Fault         = 1'b0;
    take          = 1'b0;
    case (state_q)
      S_IF: begin
        Mem_Req = 1'b1;
        if (Mem_Ack) begin
          IR_LdEn = 1'b1;
          PC_LdEn = 1'b1;
          state_d = S_DEC;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d = S_FAULT;
        end
      end
      S_DEC: begin
        case (opc)
          OP_R:                     state_d = S_EX_R;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EX_I;
          OP_LW, OP_SW:             state_d = S_ADDR;
          OP_B, OP_BEQ, OP_BNE:     state_d = S_BR;
          default:                  state_d = S_FAULT;
        endcase
      end
      S_EX_R: begin
        ALU_func = Instr[FUNC_W-1:0];
        state_d  = S_WB_ALU;
      end
      S_EX_I: begin
        ALU_Bin_sel = 1'b1;
        if (opc == OP_ANDI)     ALU_func = FUNC_W'(2);
        else if (opc == OP_ORI) ALU_func = FUNC_W'(3);
        state_d = S_WB_ALU;
      end
      S_ADDR: begin
        ALU_Bin_sel = 1'b1;
        state_d     = S_MEM;
      end
      S_MEM: begin
        Mem_Req  = 1'b1;
        MEM_WrEn = (opc == OP_SW);
        if (Mem_Ack)                     state_d = (opc == OP_SW) ? S_IF : S_WB_MEM;
        else if (wait_cnt == WAIT_LAST)  state_d = S_FAULT;
      end
      S_WB_ALU: begin
        RF_WrEn = 1'b1;
        state_d = S_IF;
      end
      S_WB_MEM: begin
        RF_WrEn       = 1'b1;
        RF_WrData_sel = 1'b1;
        state_d       = S_IF;
      end
      S_BR: begin
        ALU_func = FUNC_W'(1);
        take     = (opc == OP_B) || (opc == OP_BEQ && Zero) || (opc == OP_BNE && !Zero);
        PC_sel   = take;
        PC_LdEn  = take;
        state_d  = S_IF;
      end
      S_FAULT: Fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
  end

`ifdef CTRL_RETIRED_CNT_EN
  // An instruction retires on the edge that returns the FSM to IF from a
  // completing state; MEM only returns to IF for SW.
  logic [31:0] retired_q;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      retired_q <= '0;
    else if (state_d == S_IF &&
             (state_q == S_WB_ALU || state_q == S_WB_MEM ||
              state_q == S_MEM    || state_q == S_BR))
      retired_q <= retired_q + 32'd1;
  end
  assign Retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each stimulus cycle pushes the
// hand-computed output vector for that cycle into a queue; a monitor on the
// falling edge pops and compares against the live DUT outputs.
module tb_multicycle_control;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        Mem_Ack;
  logic        PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        MEM_WrEn, Mem_Req, Fault;
`ifdef CTRL_RETIRED_CNT_EN
  logic [31:0] Retired;
`endif

  multicycle_control #(.FUNC_W(4), .TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .Mem_Ack(Mem_Ack),
    .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func),
    .MEM_WrEn(MEM_WrEn), .Mem_Req(Mem_Req),
`ifdef CTRL_RETIRED_CNT_EN
    .Retired(Retired),
`endif
    .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [12:0] o;
    logic [31:0] ret;
    bit          ret_en;
    string       nm;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          ret_pend = 0;
  logic [31:0] ret_val  = '0;

  // {PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, ALU_Bin_sel, ALU_func, MEM_WrEn, Mem_Req, Fault}
  function automatic logic [12:0] ex(input logic pcs, pcl, irl, rfw, rfd, abs,
                                     input logic [3:0] fn, input logic mw, mr, f);
    return {pcs, pcl, irl, rfw, rfd, abs, fn, mw, mr, f};
  endfunction

  localparam logic [31:0] I_R    = 32'h8000_0005;
  localparam logic [31:0] I_ADDI = 32'hC000_0007;
  localparam logic [31:0] I_ANDI = 32'hC800_0000;
  localparam logic [31:0] I_ORI  = 32'hCC00_0000;
  localparam logic [31:0] I_LW   = 32'h3C00_0000;
  localparam logic [31:0] I_SW   = 32'h7C00_0000;
  localparam logic [31:0] I_B    = 32'hFC00_0000;
  localparam logic [31:0] I_BEQ  = 32'h4000_0000;
  localparam logic [31:0] I_BNE  = 32'h4400_0000;
  localparam logic [31:0] I_BAD  = 32'h0400_0000;

  logic [12:0] e_ifw, e_ifa, e_z, e_wba, e_wbm, e_addr, e_memr, e_memw, e_flt, e_brt, e_brn;
  initial begin
    e_ifw  = ex(0,0,0,0,0,0,4'd0,0,1,0);
    e_ifa  = ex(0,1,1,0,0,0,4'd0,0,1,0);
    e_z    = ex(0,0,0,0,0,0,4'd0,0,0,0);
    e_wba  = ex(0,0,0,1,0,0,4'd0,0,0,0);
    e_wbm  = ex(0,0,0,1,1,0,4'd0,0,0,0);
    e_addr = ex(0,0,0,0,0,1,4'd0,0,0,0);
    e_memr = ex(0,0,0,0,0,0,4'd0,0,1,0);
    e_memw = ex(0,0,0,0,0,0,4'd0,1,1,0);
    e_flt  = ex(0,0,0,0,0,0,4'd0,0,0,1);
    e_brt  = ex(1,1,0,0,0,0,4'd1,0,0,0);
    e_brn  = ex(0,0,0,0,0,0,4'd1,0,0,0);
  end

  task automatic push(input logic [12:0] e, input string nm);
    exp_t x;
    x.o = e; x.nm = nm; x.ret_en = ret_pend; x.ret = ret_val;
    ret_pend = 0;
    q.push_back(x);
  endtask

  // Drive one cycle's inputs, record its expectation, move to next cycle.
  task automatic cyc(input logic [31:0] ins, input logic z, input logic ack,
                     input logic [12:0] e, input string nm);
    Instr = ins; Zero = z; Mem_Ack = ack;
    push(e, nm);
    @(posedge Clk); #1;
  endtask

  // Assert reset mid-cycle; outputs must show IF immediately.
  task automatic rst(input string nm);
    Reset = 1'b0; Mem_Ack = 1'b0;
    push(e_ifw, nm);
    @(posedge Clk); #1;
    Reset = 1'b1;
  endtask

  task automatic run_r;
    cyc(I_R, 0, 1, e_ifa, "r_if");
    cyc(I_R, 0, 0, e_z,   "r_dec");
    cyc(I_R, 0, 0, ex(0,0,0,0,0,0,4'd5,0,0,0), "r_ex");
    cyc(I_R, 0, 0, e_wba, "r_wb");
  endtask

  task automatic run_i(input logic [31:0] ins, input logic [3:0] fn, input string nm);
    cyc(ins, 0, 1, e_ifa, {nm, "_if"});
    cyc(ins, 0, 0, e_z,   {nm, "_dec"});
    cyc(ins, 0, 0, ex(0,0,0,0,0,1,fn,0,0,0), {nm, "_ex"});
    cyc(ins, 0, 0, e_wba, {nm, "_wb"});
  endtask

  task automatic run_br(input logic [31:0] ins, input logic z, input logic [12:0] e, input string nm);
    cyc(ins, 0, 1, e_ifa, {nm, "_if"});
    cyc(ins, 0, 0, e_z,   {nm, "_dec"});
    cyc(ins, z, 0, e,     {nm, "_br"});
  endtask

  task automatic run_sw;
    cyc(I_SW, 0, 1, e_ifa,  "sw_if");
    cyc(I_SW, 0, 0, e_z,    "sw_dec");
    cyc(I_SW, 0, 0, e_addr, "sw_addr");
    cyc(I_SW, 0, 1, e_memw, "sw_mem");
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [12:0] got;
      x   = q.pop_front();
      got = {PC_sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, ALU_Bin_sel,
             ALU_func, MEM_WrEn, Mem_Req, Fault};
      checks++;
      if (got !== x.o) begin
        errors++;
        $display("FAIL %s: outputs got %b want %b", x.nm, got, x.o);
      end
`ifdef CTRL_RETIRED_CNT_EN
      if (x.ret_en) begin
        checks++;
        if (Retired !== x.ret) begin
          errors++;
          $display("FAIL %s retired: got %0h want %0h", x.nm, Retired, x.ret);
        end
      end
`endif
    end
  end

  initial begin
    Reset = 1'b0; Instr = '0; Zero = 1'b0; Mem_Ack = 1'b0;
    #30 Reset = 1'b1;
    @(posedge Clk); #1;

    // Fetch after reset with two wait cycles, then R-type; Mem_Ack in DEC ignored.
    cyc(I_R, 0, 0, e_ifw, "rst_fetch");
    cyc(I_R, 0, 0, e_ifw, "if_wait");
    cyc(I_R, 0, 1, e_ifa, "r_if");
    cyc(I_R, 0, 1, e_z,   "dec_ack_ignored");
    cyc(I_R, 0, 0, ex(0,0,0,0,0,0,4'd5,0,0,0), "r_ex");
    cyc(I_R, 0, 0, e_wba, "r_wb");

    run_i(I_ADDI, 4'd0, "addi");
    run_i(I_ANDI, 4'd2, "andi");
    run_i(I_ORI,  4'd3, "ori");

    // LW with three MEM cycles before ack.
    cyc(I_LW, 0, 1, e_ifa,  "lw_if");
    cyc(I_LW, 0, 0, e_z,    "lw_dec");
    cyc(I_LW, 0, 0, e_addr, "lw_addr");
    cyc(I_LW, 0, 0, e_memr, "lw_mem1");
    cyc(I_LW, 0, 0, e_memr, "lw_mem2");
    cyc(I_LW, 0, 1, e_memr, "lw_mem3");
    cyc(I_LW, 0, 0, e_wbm,  "lw_wb");

    run_sw;
    run_br(I_B,   0, e_brt, "b");
    run_br(I_BEQ, 1, e_brt, "beq_z1");
    run_br(I_BEQ, 0, e_brn, "beq_z0");
    run_br(I_BNE, 1, e_brn, "bne_z1");
    run_br(I_BNE, 0, e_brt, "bne_z0");

    // Illegal opcode -> FAULT, sticky even with Mem_Ack.
    cyc(I_BAD, 0, 1, e_ifa, "bad_if");
    cyc(I_BAD, 0, 0, e_z,   "bad_dec");
    cyc(I_BAD, 0, 0, e_flt, "bad_fault");
    cyc(I_BAD, 0, 1, e_flt, "fault_hold");
    rst("fault_clear");

    // Fetch timeout: 16 request cycles in IF, then FAULT.
    for (int i = 0; i < 16; i++) cyc(I_R, 0, 0, e_ifw, "to_wait");
    for (int i = 0; i < 3; i++)  cyc(I_R, 0, 0, e_flt, "to_fault");
    rst("to_clear");

    // Reset in the middle of an SW access.
    cyc(I_SW, 0, 1, e_ifa,  "swr_if");
    cyc(I_SW, 0, 0, e_z,    "swr_dec");
    cyc(I_SW, 0, 0, e_addr, "swr_addr");
    cyc(I_SW, 0, 0, e_memw, "swr_mem");
    rst("rst_in_mem");
    cyc(I_R, 0, 0, e_ifw, "post_rst_fetch");

`ifdef CTRL_RETIRED_CNT_EN
    rst("ret_rst");
    run_r;
    run_i(I_ADDI, 4'd0, "r_addi");
    cyc(I_LW, 0, 1, e_ifa,  "r_lw_if");
    cyc(I_LW, 0, 0, e_z,    "r_lw_dec");
    cyc(I_LW, 0, 0, e_addr, "r_lw_addr");
    cyc(I_LW, 0, 1, e_memr, "r_lw_mem");
    cyc(I_LW, 0, 0, e_wbm,  "r_lw_wb");
    run_sw;
    run_br(I_BEQ, 1, e_brt, "r_beq");
    ret_pend = 1; ret_val = 32'd5;
    cyc(I_B, 0, 0, e_ifw, "ret_five");
    dut.retired_q = 32'hFFFF_FFFF;
    run_br(I_B, 0, e_brt, "r_b");
    ret_pend = 1; ret_val = 32'd0;
    cyc(I_B, 0, 0, e_ifw, "ret_wrap");
`endif

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge Clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter FUNC_W, default 4, width of ALU_func and of the R-type function field Instr[FUNC_W-1:0].
REQ-002 Parameter TIMEOUT, default 16, maximum Mem_Req cycles without Mem_Ack before fault (range 1..255).
REQ-003 Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Instr  in  32  instruction word from instruction register; opcode = Instr[31:26].
REQ-006 Zero  in  1  ALU zero flag, valid in BR state.
REQ-007 Mem_Ack  in  1  memory completion strobe, one cycle per access.
REQ-008 PC_sel  out  1  0 = PC+4, 1 = branch target.
REQ-009 PC_LdEn  out  1  PC load enable.
REQ-010 IR_LdEn  out  1  instruction register load enable.
REQ-011 RF_WrEn  out  1  register file write enable.
REQ-012 RF_WrData_sel  out  1  0 = ALU result, 1 = memory data.
REQ-013 ALU_Bin_sel  out  1  0 = register B, 1 = immediate.
REQ-014 ALU_func  out  FUNC_W  ALU operation code.
REQ-015 MEM_WrEn  out  1  data memory write enable.
REQ-016 Mem_Req  out  1  memory access request (fetch or data).
REQ-017 Fault  out  1  sticky fault indicator.
REQ-018 Retired  out  32  retired-instruction count (present only with CTRL_RETIRED_CNT_EN).

Function
REQ-019 States SHALL be IF, DEC, EX_R, EX_I, ADDR, MEM, WB_ALU, WB_MEM, BR, FAULT; all outputs Moore-decoded from state, plus Mem_Ack in IF.
REQ-020 Opcodes: 100000 R-type (ALU_func = Instr[FUNC_W-1:0]); 110000 ADDI (func 0); 110010 ANDI (func 2); 110011 ORI (func 3); 001111 LW; 011111 SW; 111111 B; 010000 BEQ; 010001 BNE.
REQ-021 IF: Mem_Req=1; in the cycle Mem_Ack=1, IR_LdEn=1, PC_LdEn=1, PC_sel=0, next DEC.
REQ-022 DEC (1 cycle): R-type -> EX_R; ADDI/ANDI/ORI -> EX_I; LW/SW -> ADDR; B/BEQ/BNE -> BR; any other opcode -> FAULT.
REQ-023 EX_R: ALU_Bin_sel=0; EX_I: ALU_Bin_sel=1; both -> WB_ALU.
REQ-024 WB_ALU: RF_WrEn=1, RF_WrData_sel=0 -> IF.
REQ-025 ADDR: ALU_Bin_sel=1, ALU_func=0 -> MEM.
REQ-026 MEM: Mem_Req=1, MEM_WrEn=1 for SW; on Mem_Ack, SW -> IF, LW -> WB_MEM.
REQ-027 WB_MEM: RF_WrEn=1, RF_WrData_sel=1 -> IF.
REQ-028 BR: ALU_Bin_sel=0, ALU_func=1 (subtract); PC_LdEn=PC_sel=1 when B, BEQ with Zero=1, or BNE with Zero=0; else both 0; -> IF.
REQ-029 Latency with zero-wait memory: R/I-type 4 cycles, LW 5, SW 4, branch 3.
REQ-030 Wait counter SHALL clear on entry to IF/MEM and count Mem_Req cycles; reaching TIMEOUT without Mem_Ack -> FAULT.
REQ-031 Mem_Ack while Mem_Req=0 SHALL be ignored.
REQ-032 FAULT: Fault=1, all enables and Mem_Req 0, held until reset.
REQ-033 Outputs not named active in a state SHALL be 0 (ALU_func 0).

Reset
REQ-034 Reset=0 SHALL immediately force state IF, wait counter 0, Retired 0, Fault 0, including mid-access.
REQ-035 First cycle after Reset release SHALL assert Mem_Req (fetch).

Configuration
REQ-036 With CTRL_RETIRED_CNT_EN defined, Retired SHALL increment by 1 on each transition into IF from WB_ALU, WB_MEM, MEM (SW) or BR, wrapping 0xFFFFFFFF -> 0.
REQ-037 Without CTRL_RETIRED_CNT_EN, port Retired and its counter SHALL not exist.

Verification
REQ-038 Reset low 30 ns, then Instr=R-type func 5, Mem_Ack immediate -> states IF,DEC,EX_R,WB_ALU; ALU_func=5; RF_WrEn one cycle.
REQ-039 LW with Mem_Ack delayed 3 cycles in MEM -> Mem_Req high 3 cycles, then WB_MEM with RF_WrData_sel=1.
REQ-040 BEQ Zero=1 -> PC_sel=PC_LdEn=1 in BR; BNE Zero=1 -> both 0.
REQ-041 No Mem_Ack for TIMEOUT=16 cycles in IF -> Fault=1, stays 1; Reset low clears it.
REQ-042 Opcode 000001 -> FAULT after DEC; Reset asserted during MEM -> IF immediately, MEM_WrEn 0.
REQ-043 With CTRL_RETIRED_CNT_EN, five mixed instructions -> Retired=5; preload near-wrap -> rolls to 0.
